// File: rtl/rega_countdown_ctrl.sv
// rega_countdown_ctrl: BCD mm:ss irrigation countdown with valve drive.
// Loads a preset, decrements once per TICK_DIV clocks, pulses done at 00:00.
module rega_countdown_ctrl #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       init_n,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  input  logic [3:0] preset_min_t,
  input  logic [3:0] preset_min_u,
  input  logic [3:0] preset_sec_t,
  input  logic [3:0] preset_sec_u,
  output logic [3:0] min_t,
  output logic [3:0] min_u,
  output logic [3:0] sec_t,
  output logic [3:0] sec_u,
  output logic       valve,
  output logic       busy,
  output logic       done,
  output logic       bad_preset
);

  // TICK_DIV must be at least 2, so the prescaler is always at least one bit wide.
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  // Digit index 0 = sec_u, 1 = sec_t, 2 = min_u, 3 = min_t.
  localparam logic [3:0][3:0] DIGIT_MAX = {4'd5, 4'd9, 4'd5, 4'd9};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   presc_reg, presc_next;
  logic [3:0][3:0] digit_reg, digit_next;
  logic            valve_reg, valve_next;
  logic            bad_reg, bad_next;

  logic [3:0][3:0] preset_digit;
  logic [3:0][3:0] digit_dec;
  logic [3:0]      borrow;
  logic [3:0]      digit_ok;
  logic            preset_valid;
  logic            dec_zero;
  logic            tick;

  assign preset_digit = {preset_min_t, preset_min_u, preset_sec_t, preset_sec_u};
  assign borrow[0]    = 1'b1;

  // Borrow chain: a digit at 0 wraps to its maximum and borrows from the next one up.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      assign digit_dec[gi] = !borrow[gi]           ? digit_reg[gi] :
                             (digit_reg[gi] == 4'd0) ? DIGIT_MAX[gi] :
                                                       digit_reg[gi] - 4'd1;
      assign digit_ok[gi]  = (preset_digit[gi] <= DIGIT_MAX[gi]);
      if (gi < 3) begin : g_borrow
        assign borrow[gi+1] = borrow[gi] && (digit_reg[gi] == 4'd0);
      end
    end
  endgenerate

  assign preset_valid = (&digit_ok) && (preset_digit != '0);
  assign dec_zero     = (digit_dec == '0);
  assign tick         = (presc_reg == PRESC_LAST);

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state_reg <= ST_IDLE;
      presc_reg <= '0;
      digit_reg <= '0;
      valve_reg <= 1'b0;
      bad_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      presc_reg <= presc_next;
      digit_reg <= digit_next;
      valve_reg <= valve_next;
      bad_reg   <= bad_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    presc_next = presc_reg;
    digit_next = digit_reg;
    valve_next = 1'b0;
    bad_next   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (preset_valid) begin
            digit_next = preset_digit;
            presc_next = '0;
            valve_next = 1'b1;
            state_next = ST_RUN;
          end else begin
            bad_next = 1'b1;
          end
        end
      end

      // A paused cycle with pause released counts like a run cycle, so the
      // run is stretched by exactly the number of cycles spent in PAUSE.
      ST_RUN, ST_PAUSE: begin
        if (abort) begin
          digit_next = '0;
          presc_next = '0;
          state_next = ST_IDLE;
        end else if (pause) begin
          state_next = ST_PAUSE;
        end else if (tick) begin
          presc_next = '0;
          digit_next = digit_dec;
          if (dec_zero) begin
            state_next = ST_DONE;
          end else begin
            valve_next = 1'b1;
            state_next = ST_RUN;
          end
        end else begin
          presc_next = presc_reg + PW'(1);
          valve_next = 1'b1;
          state_next = ST_RUN;
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        digit_next = '0;
        presc_next = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  assign min_t      = digit_reg[3];
  assign min_u      = digit_reg[2];
  assign sec_t      = digit_reg[1];
  assign sec_u      = digit_reg[0];
  assign valve      = valve_reg;
  assign busy       = (state_reg == ST_RUN) || (state_reg == ST_PAUSE);
  assign done       = (state_reg == ST_DONE);
  assign bad_preset = bad_reg;

endmodule

// File: tb/tb_rega_countdown_ctrl.sv
// Scoreboard bench for rega_countdown_ctrl: stimulus queues expected output
// events, a monitor classifies each observed change and checks it in order.
module tb_rega_countdown_ctrl;

  localparam int EV_START  = 1;
  localparam int EV_TICK   = 2;
  localparam int EV_PAUSE  = 3;
  localparam int EV_RESUME = 4;
  localparam int EV_DONE   = 5;
  localparam int EV_BAD    = 6;
  localparam int EV_STOP   = 7;

  typedef struct {
    int          kind;
    int          at;
    logic [15:0] dig;
    logic [3:0]  flags;
  } ev_t;

  logic       clk;
  logic       init_n;
  logic       start, pause, abort;
  logic [3:0] preset_min_t, preset_min_u, preset_sec_t, preset_sec_u;
  logic [3:0] min_t, min_u, sec_t, sec_u;
  logic       valve, busy, done, bad_preset;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];

  rega_countdown_ctrl #(.TICK_DIV(4)) dut (
    .clk          (clk),
    .init_n       (init_n),
    .start        (start),
    .pause        (pause),
    .abort        (abort),
    .preset_min_t (preset_min_t),
    .preset_min_u (preset_min_u),
    .preset_sec_t (preset_sec_t),
    .preset_sec_u (preset_sec_u),
    .min_t        (min_t),
    .min_u        (min_u),
    .sec_t        (sec_t),
    .sec_u        (sec_u),
    .valve        (valve),
    .busy         (busy),
    .done         (done),
    .bad_preset   (bad_preset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Flags are {valve, busy, done, bad_preset} expected while the event is visible.
  function automatic void expect_ev(input int kind, input int at, input logic [15:0] dig);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    e.dig  = dig;
    case (kind)
      EV_START, EV_TICK, EV_RESUME: e.flags = 4'b1100;
      EV_PAUSE:                     e.flags = 4'b0100;
      EV_DONE:                      e.flags = 4'b0010;
      EV_BAD:                       e.flags = 4'b0001;
      default:                      e.flags = 4'b0000;
    endcase
    exp_q.push_back(e);
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, actual, required);
    end else begin
      $display("check %s ok: %h", name, actual);
    end
  endtask

  task automatic wait_cyc(input int target);
    int guard;
    guard = 0;
    while (cyc < target && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != target) begin
      checks++;
      errors++;
      $display("FAIL wait_cyc: got cycle %0d, required %0d", cyc, target);
    end
  endtask

  // Drives start at a negedge and leaves it high; c is the cycle it is driven in.
  task automatic drive_start(input logic [15:0] p, output int c);
    @(negedge clk);
    {preset_min_t, preset_min_u, preset_sec_t, preset_sec_u} = p;
    start = 1'b1;
    c = cyc;
  endtask

  task automatic release_start();
    @(negedge clk);
    start = 1'b0;
  endtask

  // Monitor: one event per cycle, chosen by priority, compared with the queue head.
  int          mon_kind;
  logic [15:0] mon_dig;
  logic [3:0]  mon_flags;
  ev_t         mon_e;
  logic        prev_busy = 1'b0;
  logic        prev_valve = 1'b0;
  logic [15:0] prev_dig = 16'h0000;

  initial begin
    forever begin
      @(negedge clk);
      mon_dig   = {min_t, min_u, sec_t, sec_u};
      mon_flags = {valve, busy, done, bad_preset};
      mon_kind  = 0;
      if (done === 1'b1)                          mon_kind = EV_DONE;
      else if (bad_preset === 1'b1)               mon_kind = EV_BAD;
      else if (busy === 1'b1 && !prev_busy)       mon_kind = EV_START;
      else if (busy === 1'b0 && prev_busy)        mon_kind = EV_STOP;
      else if (valve === 1'b0 && prev_valve)      mon_kind = EV_PAUSE;
      else if (valve === 1'b1 && !prev_valve)     mon_kind = EV_RESUME;
      else if (mon_dig !== prev_dig)              mon_kind = EV_TICK;
      if (mon_kind != 0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got kind=%0d cyc=%0d digits=%h flags=%b, required no event",
                   mon_kind, cyc, mon_dig, mon_flags);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.kind != mon_kind || mon_e.at != cyc || mon_e.dig !== mon_dig ||
              mon_e.flags !== mon_flags) begin
            errors++;
            $display("FAIL event: got kind=%0d cyc=%0d digits=%h flags=%b, required kind=%0d cyc=%0d digits=%h flags=%b",
                     mon_kind, cyc, mon_dig, mon_flags, mon_e.kind, mon_e.at, mon_e.dig, mon_e.flags);
          end else begin
            $display("event kind=%0d cyc=%0d digits=%h flags=%b ok", mon_kind, cyc, mon_dig, mon_flags);
          end
        end
      end
      prev_busy  = (busy === 1'b1);
      prev_valve = (valve === 1'b1);
      prev_dig   = mon_dig;
    end
  end

  logic [15:0] bad_tab [4];
  int c;

  initial begin
    bad_tab[0] = 16'h0061;
    bad_tab[1] = 16'h0000;
    bad_tab[2] = 16'h6000;
    bad_tab[3] = 16'h000A;
    start = 1'b0;
    pause = 1'b0;
    abort = 1'b0;
    {preset_min_t, preset_min_u, preset_sec_t, preset_sec_u} = 16'h0000;
    init_n = 1'b1;
    #2 init_n = 1'b0;
    @(negedge clk);
    check("reset_outputs", {12'h0, min_t, min_u, sec_t, sec_u, valve, busy, done, bad_preset}, 32'h0);
    repeat (2) @(negedge clk);
    init_n = 1'b1;
    @(negedge clk);

    // 00:03 run, then a valid start during the DONE cycle that must be ignored.
    drive_start(16'h0003, c);
    expect_ev(EV_START, c + 1,  16'h0003);
    expect_ev(EV_TICK,  c + 5,  16'h0002);
    expect_ev(EV_TICK,  c + 9,  16'h0001);
    expect_ev(EV_DONE,  c + 13, 16'h0000);
    release_start();
    wait_cyc(c + 13);
    {preset_min_t, preset_min_u, preset_sec_t, preset_sec_u} = 16'h0005;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);

    // 10:00 borrows through every digit; start during RUN is ignored; abort ends it.
    drive_start(16'h1000, c);
    expect_ev(EV_START, c + 1,  16'h1000);
    expect_ev(EV_TICK,  c + 5,  16'h0959);
    expect_ev(EV_TICK,  c + 9,  16'h0958);
    expect_ev(EV_STOP,  c + 11, 16'h0000);
    release_start();
    wait_cyc(c + 6);
    {preset_min_t, preset_min_u, preset_sec_t, preset_sec_u} = 16'h0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(c + 10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (3) @(negedge clk);

    // Rejected presets.
    for (int i = 0; i < 4; i++) begin
      drive_start(bad_tab[i], c);
      expect_ev(EV_BAD, c + 1, 16'h0000);
      release_start();
      repeat (2) @(negedge clk);
    end
    check("idle_after_bad", {30'h0, busy, valve}, 32'h0);

    // pause/abort in IDLE have no effect.
    pause = 1'b1;
    abort = 1'b1;
    repeat (3) @(negedge clk);
    pause = 1'b0;
    abort = 1'b0;
    @(negedge clk);

    // Largest legal preset 59:59.
    drive_start(16'h5959, c);
    expect_ev(EV_START, c + 1, 16'h5959);
    expect_ev(EV_TICK,  c + 5, 16'h5958);
    expect_ev(EV_STOP,  c + 7, 16'h0000);
    release_start();
    wait_cyc(c + 6);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (2) @(negedge clk);

    // 00:02 with pause high for 7 edges, the first coinciding with a tick.
    drive_start(16'h0002, c);
    expect_ev(EV_START,  c + 1,  16'h0002);
    expect_ev(EV_PAUSE,  c + 5,  16'h0002);
    expect_ev(EV_RESUME, c + 12, 16'h0001);
    expect_ev(EV_DONE,   c + 16, 16'h0000);
    release_start();
    wait_cyc(c + 4);
    pause = 1'b1;
    wait_cyc(c + 11);
    pause = 1'b0;
    wait_cyc(c + 18);

    // Abort at 00:01: no done pulse afterwards.
    drive_start(16'h0002, c);
    expect_ev(EV_START, c + 1, 16'h0002);
    expect_ev(EV_TICK,  c + 5, 16'h0001);
    expect_ev(EV_STOP,  c + 7, 16'h0000);
    release_start();
    wait_cyc(c + 6);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (6) @(negedge clk);

    // Asynchronous reset between edges mid-run.
    drive_start(16'h0003, c);
    expect_ev(EV_START, c + 1, 16'h0003);
    expect_ev(EV_TICK,  c + 5, 16'h0002);
    release_start();
    wait_cyc(c + 6);
    @(posedge clk);
    #2;
    init_n = 1'b0;
    expect_ev(EV_STOP, cyc, 16'h0000);
    #1;
    check("async_reset_outputs", {12'h0, min_t, min_u, sec_t, sec_u, valve, busy, done, bad_preset}, 32'h0);
    @(negedge clk);
    repeat (2) @(negedge clk);
    init_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_release", {12'h0, min_t, min_u, sec_t, sec_u, valve, busy, done, bad_preset}, 32'h0);
    drive_start(16'h0001, c);
    expect_ev(EV_START, c + 1, 16'h0001);
    expect_ev(EV_DONE,  c + 5, 16'h0000);
    release_start();
    wait_cyc(c + 8);

    check("pending_events", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
